// File: rtl/mu0_trace_buffer_if.sv
// Snoop and pop-port bundle between the MU0 core / host debugger and the trace buffer.
// The trace buffer connects through the slave modport.
interface mu0_trace_buffer_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 16
);
  logic              dut_fetch;
  logic [ADDR_W-1:0] dut_addr;
  logic [DATA_W-1:0] dut_data_in;
  logic              rd_ready;
  logic              rd_valid;
  logic [ADDR_W-1:0] rd_pc;
  logic [DATA_W-1:0] rd_instr;

  modport master (
    output dut_fetch, dut_addr, dut_data_in, rd_ready,
    input  rd_valid, rd_pc, rd_instr
  );

  modport slave (
    input  dut_fetch, dut_addr, dut_data_in, rd_ready,
    output rd_valid, rd_pc, rd_instr
  );
endinterface

// File: rtl/mu0_trace_buffer.sv
// MU0 instruction-trace buffer: snoops fetch cycles into a circular buffer of {pc, instr}
// entries, drained by the host through a valid/ready pop port.
module mu0_trace_buffer #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned CNT_W  = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  mu0_trace_buffer_if.slave       bus,
  input  logic                    arm,
  input  logic                    stop,
  input  logic                    clear,
  input  logic                    wrap,
  input  logic                    trig_en,
  input  logic [ADDR_W-1:0]       trig_addr,
  output logic [CNT_W-1:0]        count,
  output logic                    overflow,
  output logic                    trig_hit,
  output logic                    capturing
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned EntW = ADDR_W + DATA_W;

  typedef enum logic [1:0] {StIdle, StArmed, StCapture, StFrozen} state_e;

  state_e            state_q, state_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              trig_hit_q, trig_hit_d;
  logic [EntW-1:0]   head_q, head_d;
  logic [EntW-1:0]   entry;
  logic [EntW-1:0]   mem_q [DEPTH];
  logic              trig_match, push, pop, full, mem_we;

  assign entry      = {bus.dut_addr, bus.dut_data_in};
  assign trig_match = bus.dut_fetch && (bus.dut_addr == trig_addr);
  assign full       = (count_q == CNT_W'(DEPTH));
  assign pop        = (count_q != '0) && bus.rd_ready && !clear;
  // The trigger fetch itself is the first recorded entry of the session.
  assign push       = !clear && bus.dut_fetch &&
                      ((state_q == StCapture) || ((state_q == StArmed) && trig_match && !stop));

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    mem_we     = 1'b0;
    trig_hit_d = (state_q == StArmed) && trig_match && !stop;

    case (state_q)
      StIdle, StFrozen: if (arm && !stop) state_d = trig_en ? StArmed : StCapture;
      StArmed: begin
        if (stop) state_d = StFrozen;
        else if (trig_match) state_d = StCapture;
      end
      StCapture: if (stop) state_d = StFrozen;
      default: state_d = StIdle;
    endcase

    if (clear) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else if (push && full && !pop) begin
      overflow_d = 1'b1;
      if (wrap) begin
        // Overwrite the oldest slot; write and read pointers advance together.
        mem_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + PtrW'(1);
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end else begin
        state_d = StFrozen;
      end
    end else begin
      if (push) begin
        mem_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PtrW'(1);
      if (push && !pop) count_d = count_q + CNT_W'(1);
      else if (pop && !push) count_d = count_q - CNT_W'(1);
    end

    // Head register tracks the next-cycle head, bypassing an entry written this cycle.
    if (count_d == '0) head_d = '0;
    else if (mem_we && (rd_ptr_d == wr_ptr_q)) head_d = entry;
    else head_d = mem_q[rd_ptr_d];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      trig_hit_q <= 1'b0;
      head_q     <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      trig_hit_q <= trig_hit_d;
      head_q     <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_ptr_q] <= entry;
  end

  assign bus.rd_valid = (count_q != '0);
  assign bus.rd_pc    = head_q[EntW-1:DATA_W];
  assign bus.rd_instr = head_q[DATA_W-1:0];
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign trig_hit     = trig_hit_q;
  assign capturing    = (state_q == StCapture);
endmodule

// File: tb/tb_mu0_trace_buffer.sv
// Directed bench for mu0_trace_buffer: a queue holds expected {pc, instr} entries and is
// compared against the head of the DUT on every pop.
module tb_mu0_trace_buffer;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = 5;

  logic              clk = 1'b0;
  logic              reset, arm, stop, clear, wrap, trig_en;
  logic [ADDR_W-1:0] trig_addr;
  logic [CNT_W-1:0]  count;
  logic              overflow, trig_hit, capturing;

  int passed = 0;
  int total  = 0;
  logic [ADDR_W+DATA_W-1:0] sb[$];

  always #5 clk = ~clk;

  mu0_trace_buffer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mu0_trace_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .arm       (arm),
    .stop      (stop),
    .clear     (clear),
    .wrap      (wrap),
    .trig_en   (trig_en),
    .trig_addr (trig_addr),
    .count     (count),
    .overflow  (overflow),
    .trig_hit  (trig_hit),
    .capturing (capturing)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic pulse_arm(input logic te);
    trig_en = te;
    arm = 1'b1;
    step();
    arm = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
    sb.delete();
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  // cap: the bench expects this fetch to be recorded (wrap drops the oldest when full).
  task automatic fetch(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input bit cap);
    bus.dut_fetch   = 1'b1;
    bus.dut_addr    = a;
    bus.dut_data_in = d;
    if (cap) begin
      if (sb.size() == DEPTH) void'(sb.pop_front());
      sb.push_back({a, d});
    end
    step();
    bus.dut_fetch = 1'b0;
  endtask

  task automatic pop_check(input string tag);
    logic [ADDR_W+DATA_W-1:0] exp;
    check({tag, "_valid"}, 32'(bus.rd_valid), 32'd1);
    if (sb.size() == 0) begin
      total++;
      $error("FAIL %s_model: observed pop expected none", tag);
    end else begin
      exp = sb.pop_front();
      check({tag, "_entry"}, 32'({bus.rd_pc, bus.rd_instr}), 32'(exp));
    end
    bus.rd_ready = 1'b1;
    step();
    bus.rd_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; arm = 1'b0; stop = 1'b0; clear = 1'b0; wrap = 1'b0; trig_en = 1'b0;
    trig_addr = '0;
    bus.dut_fetch = 1'b0; bus.dut_addr = '0; bus.dut_data_in = '0; bus.rd_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
    check("rst_count", 32'(count), 32'd0);
    check("rst_valid", 32'(bus.rd_valid), 32'd0);
    check("rst_pc", 32'(bus.rd_pc), 32'd0);
    check("rst_instr", 32'(bus.rd_instr), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_trig_hit", 32'(trig_hit), 32'd0);
    check("rst_capturing", 32'(capturing), 32'd0);

    // Basic capture and drain.
    pulse_arm(1'b0);
    check("t1_capturing", 32'(capturing), 32'd1);
    fetch(12'h000, 16'h1005, 1'b1);
    fetch(12'h001, 16'h2006, 1'b1);
    fetch(12'h002, 16'h7000, 1'b1);
    check("t1_count", 32'(count), 32'd3);
    for (int i = 0; i < 3; i++) pop_check("t1_pop");
    check("t1_empty", 32'(bus.rd_valid), 32'd0);

    // Triggered capture.
    pulse_stop();
    trig_addr = 12'h010;
    pulse_arm(1'b1);
    check("t2_armed_not_capturing", 32'(capturing), 32'd0);
    fetch(12'h00E, 16'h0E0E, 1'b0);
    fetch(12'h00F, 16'h0F0F, 1'b0);
    check("t2_no_early_hit", 32'(trig_hit), 32'd0);
    fetch(12'h010, 16'h1010, 1'b1);
    check("t2_trig_hit", 32'(trig_hit), 32'd1);
    check("t2_capturing", 32'(capturing), 32'd1);
    fetch(12'h011, 16'h1111, 1'b1);
    check("t2_trig_hit_one_cycle", 32'(trig_hit), 32'd0);
    check("t2_count", 32'(count), 32'd2);
    pop_check("t2_pop");
    pop_check("t2_pop");

    // Freeze on full without wrap.
    pulse_stop();
    pulse_clear();
    wrap = 1'b0;
    pulse_arm(1'b0);
    for (int i = 0; i < 16; i++) fetch(ADDR_W'(12'h100 + i), DATA_W'(16'hA000 + i), 1'b1);
    check("t3_full_no_ovf", 32'(overflow), 32'd0);
    fetch(12'h110, 16'hA010, 1'b0);
    check("t3_count", 32'(count), 32'd16);
    check("t3_overflow", 32'(overflow), 32'd1);
    check("t3_frozen", 32'(capturing), 32'd0);
    fetch(12'h111, 16'hA011, 1'b0);
    check("t3_count_after", 32'(count), 32'd16);
    check("t3_head_pc", 32'(bus.rd_pc), 32'h100);
    pop_check("t3_pop");
    pulse_clear();
    check("t3_clear_count", 32'(count), 32'd0);
    check("t3_clear_ovf", 32'(overflow), 32'd0);

    // Wrap-around overwrite.
    wrap = 1'b1;
    pulse_arm(1'b0);
    for (int i = 0; i < 20; i++) fetch(ADDR_W'(i), DATA_W'(16'h3000 + i), 1'b1);
    check("t4_count", 32'(count), 32'd16);
    check("t4_overflow", 32'(overflow), 32'd1);
    check("t4_capturing", 32'(capturing), 32'd1);
    check("t4_head_pc", 32'(bus.rd_pc), 32'd4);
    for (int i = 0; i < 15; i++) pop_check("t4_pop");
    check("t4_last_pc", 32'(bus.rd_pc), 32'd19);
    pop_check("t4_pop_last");
    check("t4_empty", 32'(bus.rd_valid), 32'd0);

    // Full buffer, push and pop together without wrap.
    pulse_clear();
    wrap = 1'b0;
    for (int i = 0; i < 16; i++) fetch(ADDR_W'(12'h200 + i), DATA_W'(16'hB000 + i), 1'b1);
    check("t5_head", 32'({bus.rd_pc, bus.rd_instr}), 32'(sb[0]));
    void'(sb.pop_front());
    bus.rd_ready = 1'b1;
    fetch(12'h2F0, 16'hBEEF, 1'b1);
    bus.rd_ready = 1'b0;
    check("t5_count", 32'(count), 32'd16);
    check("t5_overflow", 32'(overflow), 32'd0);
    check("t5_capturing", 32'(capturing), 32'd1);
    check("t5_new_head_pc", 32'(bus.rd_pc), 32'h201);
    // Empty buffer, push and pop together: only the push takes effect.
    pulse_clear();
    bus.rd_ready = 1'b1;
    fetch(12'h300, 16'hC000, 1'b1);
    bus.rd_ready = 1'b0;
    check("t5_empty_pushpop_count", 32'(count), 32'd1);
    check("t5_empty_pushpop_head", 32'({bus.rd_pc, bus.rd_instr}), 32'(sb[0]));

    // Clear with fetch and stop, then mid-session reset.
    wrap = 1'b1;
    for (int i = 0; i < 16; i++) fetch(ADDR_W'(12'h400 + i), DATA_W'(16'hD000 + i), 1'b1);
    check("t6_overflow_set", 32'(overflow), 32'd1);
    clear = 1'b1;
    stop  = 1'b1;
    fetch(12'h500, 16'hE000, 1'b0);
    clear = 1'b0;
    stop  = 1'b0;
    sb.delete();
    check("t6_count", 32'(count), 32'd0);
    check("t6_overflow", 32'(overflow), 32'd0);
    check("t6_frozen", 32'(capturing), 32'd0);
    check("t6_valid", 32'(bus.rd_valid), 32'd0);
    pulse_arm(1'b0);
    fetch(12'h600, 16'hF000, 1'b1);
    check("t6_recapture_count", 32'(count), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    sb.delete();
    check("t6_rst_capturing", 32'(capturing), 32'd0);
    check("t6_rst_valid", 32'(bus.rd_valid), 32'd0);
    check("t6_rst_count", 32'(count), 32'd0);
    check("t6_rst_pc", 32'(bus.rd_pc), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
